// File: rtl/census_disparity_wta_if.sv
// Stream bundle between the census front-end and the disparity matcher.
`timescale 1ns/1ps
interface census_disparity_wta_if #(
  parameter int CENSUSWID = 62,
  parameter int DISPWID   = 6
);
  logic                 en;
  logic [CENSUSWID:0]   data_in_l;
  logic [CENSUSWID:0]   data_in_r;
  logic                 sof_out;
  logic [DISPWID-1:0]   disp_out;
  logic [5:0]           cost_out;
  logic                 invalid_out;

  modport master (
    output en, data_in_l, data_in_r,
    input  sof_out, disp_out, cost_out, invalid_out
  );

  modport slave (
    input  en, data_in_l, data_in_r,
    output sof_out, disp_out, cost_out, invalid_out
  );
endinterface

// File: rtl/census_disparity_wta.sv
// Census Hamming-cost matcher with pipelined winner-take-all; CENSUS_COST_THRESH_EN adds a cost threshold.
// Latency 3+DISPWID en-cycles; no backpressure, every register advances only while en=1.
`timescale 1ns/1ps
module census_disparity_wta #(
  parameter int IMAGE_WIDTH = 640,
  parameter int CENSUSWID   = 62,
  parameter int MAX_DISP    = 64,
  parameter int DISPWID     = 6,
  parameter int COST_THRESH = 24
) (
  input logic                clk,
  input logic                rst,
  census_disparity_wta_if.slave bus
);
  localparam int COLW  = $clog2(IMAGE_WIDTH);
  localparam int NPART = (CENSUSWID + 7) / 8;
  localparam int PADW  = NPART * 8;
  localparam int NNODE = 2 * MAX_DISP;
  localparam int SOFW  = DISPWID + 2;
  localparam logic [COLW-1:0] COL_LAST = COLW'(IMAGE_WIDTH - 1);

  typedef logic [CENSUSWID-1:0] code_t;
  typedef logic [5:0]           cost_t;
  typedef logic [DISPWID-1:0]   disp_t;
  typedef logic [3:0]           part_t;

  code_t     l_code, r_code;
  logic      l_sof;
  logic      unused_r_sof;

  assign l_code       = bus.data_in_l[CENSUSWID-1:0];
  assign l_sof        = bus.data_in_l[CENSUSWID];
  assign r_code       = bus.data_in_r[CENSUSWID-1:0];
  assign unused_r_sof = bus.data_in_r[CENSUSWID];

  // Candidate 0 is the live right word, so the stored line only needs MAX_DISP-1 taps.
  code_t           r_dly [MAX_DISP-1];
  code_t           cand [MAX_DISP];
  logic [COLW-1:0] col_q, col_cur;

  code_t           x_s1 [MAX_DISP];
  logic [COLW-1:0] col_s1, col_s2;
  part_t           part_nxt [MAX_DISP][NPART];
  part_t           part_s2  [MAX_DISP][NPART];
  cost_t           leaf_nxt [MAX_DISP];

  // Heap-ordered tree: node n has children 2n and 2n+1, leaves at MAX_DISP+d.
  cost_t           node_cost [2:NNODE-1];
  disp_t           node_disp [2:NNODE-1];
  cost_t           win_cost;
  disp_t           win_disp;
  logic [SOFW-1:0] sof_sr;

  function automatic part_t pop_chunk(input code_t x, input int p);
    logic [PADW-1:0] xp;
    part_t           c;
    xp = PADW'(x);
    c  = '0;
    for (int i = 0; i < 8; i++) c = c + part_t'(xp[p*8+i]);
    return c;
  endfunction

  always_comb col_cur = l_sof ? '0 : col_q;

  always_comb begin
    cand[0] = r_code;
    for (int d = 1; d < MAX_DISP; d++) cand[d] = r_dly[d-1];
  end

  always_comb begin
    for (int d = 0; d < MAX_DISP; d++)
      for (int p = 0; p < NPART; p++)
        part_nxt[d][p] = pop_chunk(x_s1[d], p);
  end

  always_comb begin : leaf_sum
    cost_t acc;
    for (int d = 0; d < MAX_DISP; d++) begin
      acc = '0;
      for (int p = 0; p < NPART; p++) acc = acc + cost_t'(part_s2[d][p]);
      leaf_nxt[d] = (d > int'(col_s2)) ? 6'd63 : acc;
    end
  end

  // Ties keep the left child, which always covers the lower disparities.
  always_comb begin
    if (node_cost[3] < node_cost[2]) begin
      win_cost = node_cost[3];
      win_disp = node_disp[3];
    end else begin
      win_cost = node_cost[2];
      win_disp = node_disp[2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < MAX_DISP-1; d++) r_dly[d] <= '0;
      for (int d = 0; d < MAX_DISP; d++) begin
        x_s1[d] <= '0;
        for (int p = 0; p < NPART; p++) part_s2[d][p] <= '0;
      end
      for (int n = 2; n < NNODE; n++) begin
        node_cost[n] <= '0;
        node_disp[n] <= (n >= MAX_DISP) ? disp_t'(n - MAX_DISP) : '0;
      end
      col_q           <= '0;
      col_s1          <= '0;
      col_s2          <= '0;
      sof_sr          <= '0;
      bus.sof_out     <= 1'b0;
      bus.disp_out    <= '0;
      bus.cost_out    <= '0;
      bus.invalid_out <= 1'b0;
    end else if (bus.en) begin
      r_dly[0] <= r_code;
      for (int d = 1; d < MAX_DISP-1; d++) r_dly[d] <= r_dly[d-1];
      col_q  <= (col_cur == COL_LAST) ? '0 : col_cur + COLW'(1);

      for (int d = 0; d < MAX_DISP; d++) x_s1[d] <= l_code ^ cand[d];
      col_s1  <= col_cur;
      part_s2 <= part_nxt;
      col_s2  <= col_s1;

      for (int d = 0; d < MAX_DISP; d++) begin
        node_cost[MAX_DISP+d] <= leaf_nxt[d];
        node_disp[MAX_DISP+d] <= disp_t'(d);
      end
      for (int n = 2; n < MAX_DISP; n++) begin
        if (node_cost[2*n+1] < node_cost[2*n]) begin
          node_cost[n] <= node_cost[2*n+1];
          node_disp[n] <= node_disp[2*n+1];
        end else begin
          node_cost[n] <= node_cost[2*n];
          node_disp[n] <= node_disp[2*n];
        end
      end

      sof_sr       <= {sof_sr[SOFW-2:0], l_sof};
      bus.sof_out  <= sof_sr[SOFW-1];
      bus.cost_out <= win_cost;
`ifdef CENSUS_COST_THRESH_EN
      if (int'(win_cost) > COST_THRESH) begin
        bus.disp_out    <= '0;
        bus.invalid_out <= 1'b1;
      end else begin
        bus.disp_out    <= win_disp;
        bus.invalid_out <= (win_cost == 6'd63);
      end
`else
      bus.disp_out    <= win_disp;
      bus.invalid_out <= (win_cost == 6'd63);
`endif
    end
  end

`ifndef CENSUS_COST_THRESH_EN
  localparam int unused_cost_thresh = COST_THRESH;
`endif

endmodule

// File: tb/tb_census_disparity_wta.sv
// Bench: per-cycle comparison against a disparity reference model plus directed line-level checks.
`timescale 1ns/1ps
module tb_census_disparity_wta;
  localparam int W = 640, CW = 62, MD = 64, DW = 6, THRESH = 24;
  localparam int LAT = 3 + DW;
`ifdef CENSUS_COST_THRESH_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif

  typedef logic [CW-1:0] code_t;
  typedef struct packed {
    logic          sof;
    logic [DW-1:0] disp;
    logic [5:0]    cost;
    logic          inv;
  } res_t;
  typedef struct {
    code_t l;
    code_t r;
    int    disp;
    int    cost;
  } vec_t;

  localparam code_t C155 = 62'h1555_5555_5555_5555;
  localparam code_t C2AA = 62'h2AAA_AAAA_AAAA_AAAA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  census_disparity_wta_if #(.CENSUSWID(CW), .DISPWID(DW)) bus ();

  census_disparity_wta #(
    .IMAGE_WIDTH(W), .CENSUSWID(CW), .MAX_DISP(MD), .DISPWID(DW), .COST_THRESH(THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  res_t got;
  assign got = {bus.sof_out, bus.disp_out, bus.cost_out, bus.invalid_out};

  int checks = 0;
  int errors = 0;

  // History of accepted input pixels since the last reset.
  code_t hl[$], hr[$];
  bit    hsof[$];
  int    hcol[$];

  function automatic code_t rnd_code();
    return code_t'({$urandom(), $urandom()});
  endfunction

  // Expected output for accepted pixel k: exhaustive best-match search over all disparities.
  function automatic res_t model(int k);
    res_t  r;
    int    best_c, best_d, c;
    code_t rc;
    r = '0;
    if (k < 0) return r;
    best_c = 1000;
    best_d = 0;
    for (int d = 0; d < MD; d++) begin
      if (d > hcol[k]) c = 63;
      else begin
        rc = (k - d >= 0) ? hr[k-d] : '0;
        c  = $countones(hl[k] ^ rc);
      end
      if (c < best_c) begin
        best_c = c;
        best_d = d;
      end
    end
    r.sof  = hsof[k];
    r.cost = 6'(best_c);
    r.disp = DW'(best_d);
    r.inv  = (best_c == 63);
    if (THR_EN && best_c > THRESH) begin
      r.disp = '0;
      r.inv  = 1'b1;
    end
    return r;
  endfunction

  task automatic chk_res(string nm, res_t act, res_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got sof=%0d disp=%0d cost=%0d inv=%0d, expected sof=%0d disp=%0d cost=%0d inv=%0d",
               nm, $time, act.sof, act.disp, act.cost, act.inv, exp.sof, exp.disp, exp.cost, exp.inv);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step(bit e, bit s, code_t l, code_t r);
    int col;
    bus.en        = e;
    bus.data_in_l = {s, l};
    bus.data_in_r = {1'($urandom_range(1)), r};
    @(posedge clk);
    #1;
    if (rst) begin
      hl.delete(); hr.delete(); hsof.delete(); hcol.delete();
    end else if (e) begin
      if (s || hcol.size() == 0) col = 0;
      else col = (hcol[$] == W - 1) ? 0 : hcol[$] + 1;
      hl.push_back(l); hr.push_back(r); hsof.push_back(s); hcol.push_back(col);
    end
    chk_res("model", got, model(hl.size() - LAT));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, C155, C155);
    step(1'b1, 1'b1, C155, C155);
    rst = 1'b0;
  endtask

  // Left = right delayed 5 columns; optional second SOF and en gaps.
  task automatic stream_run(string nm, int n, int sof2_at, int ngaps);
    code_t rs[$], ls[$];
    int    colp, gaps, p;
    bit    psof;
    do_reset();
    gaps = ngaps;
    colp = 0;
    for (int i = 0; i < n; i++) begin
      rs.push_back(rnd_code());
      ls.push_back(i >= 5 ? rs[i-5] : rnd_code());
      while (gaps > 0 && $urandom_range(7) == 0) begin
        step(1'b0, 1'($urandom_range(1)), rnd_code(), rnd_code());
        gaps--;
      end
      step(1'b1, (i == 0 || i == sof2_at), ls[i], rs[i]);
      if (i >= LAT - 1) begin
        p    = i - (LAT - 1);
        psof = (p == 0 || p == sof2_at);
        colp = psof ? 0 : ((colp == W - 1) ? 0 : colp + 1);
        chk_int({nm, " sof"}, int'(got.sof), int'(psof));
        if (colp == 0) begin
          chk_int({nm, " col0 disp"}, int'(got.disp), 0);
          chk_int({nm, " col0 cost"}, int'(got.cost), $countones(ls[p] ^ rs[p]));
        end else if (colp >= 5) begin
          chk_int({nm, " disp"}, int'(got.disp), 5);
          chk_int({nm, " cost"}, int'(got.cost), 0);
        end
      end
    end
    while (gaps > 0) begin
      step(1'b0, 1'b0, rnd_code(), rnd_code());
      gaps--;
    end
  endtask

  // Single target pixel x; right column x-da / x-db get special codes, all others rdef.
  task automatic probe(string nm, code_t lc, code_t rdef, int da, code_t ra, int db, code_t rb,
                       int x, int ed, int ec, bit ei);
    code_t rc;
    do_reset();
    for (int i = 0; i <= x + LAT - 1; i++) begin
      rc = (i == x - da) ? ra : ((i == x - db) ? rb : rdef);
      step(1'b1, (i == 0), lc, rc);
    end
    chk_res(nm, got, {1'b0, DW'(ed), 6'(ec), ei});
  endtask

  initial begin
    vec_t  tbl[6];
    code_t lt;
    bus.en        = 1'b0;
    bus.data_in_l = '0;
    bus.data_in_r = '0;

    // Reset then a constant identical code on both sides, no SOF.
    do_reset();
    chk_res("reset state", got, '0);
    for (int i = 0; i < 2 * W; i++) begin
      step(1'b1, 1'b0, C155, C155);
      if (i == LAT - 1) chk_res("const first result", got, '0);
    end
    chk_res("const two lines", got, '0);

    // Constant streams: every candidate costs the same, so the tie goes to d=0.
    tbl[0] = '{C155, C155, 0, 0};
    tbl[1] = '{C155, C2AA, 0, 62};
    tbl[2] = '{62'h0, 62'hFF, 0, 8};
    tbl[3] = '{62'h3FFF_FFFF_FFFF_FFFF, 62'h3FFF_FFFF_FFFF_FFF0, 0, 4};
    tbl[4] = '{62'hFFFF_FFFF, 62'h0, 0, 32};
    tbl[5] = '{62'h3, 62'h3000_0000_0000_0000, 0, 4};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      for (int i = 0; i < 80; i++) step(1'b1, (i == 0), tbl[t].l, tbl[t].r);
      chk_res($sformatf("table[%0d]", t), got,
              {1'b0, DW'(tbl[t].disp), 6'(tbl[t].cost), 1'(THR_EN && tbl[t].cost > THRESH)});
    end

    // Shifted stream across a full line and its wrap.
    stream_run("shift5", W + 20, -1, 0);
    // SOF injected where column 300 would have been.
    stream_run("midsof", 320, 300, 0);
    // Same kind of stream with en dropped on 10 random cycles.
    stream_run("gaps", 200, -1, 10);

    // Tie between d=3 and d=7 at distance 2; everything else is the complement.
    lt = rnd_code();
    probe("tie", lt, ~lt, 3, lt ^ 62'h3, 7, lt ^ 62'h220, 100, 3, 2, 1'b0);

    // Best cost 30 at d=4.
    probe("thresh", 62'h0, 62'h3FFF_FFFF_FFFF_FFFF, 4, 62'h3FFF_FFFF, 4, 62'h3FFF_FFFF,
          100, THR_EN ? 0 : 4, 30, THR_EN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
